// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use interlock, branch
// flushes, and memory-wait stalling with a sticky bus-error timeout.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             REGWRITE_M,
  input  logic             REGWRITE_W,
  input  logic             LOAD_E,
  input  logic             PCSRC_E,
  input  logic             MEM_REQ_M,
  input  logic             MEM_READY,
  output logic             STALL_F,
  output logic             STALL_D,
  output logic             STALL_E,
  output logic             STALL_M,
  output logic             FLUSH_D,
  output logic             FLUSH_E,
  output logic             FLUSH_W,
  output logic [1:0]       FWD_A_E,
  output logic [1:0]       FWD_B_E,
  output logic             BUS_ERR,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam logic [1:0]       S_RUN       = 2'b00;
  localparam logic [1:0]       S_MEM_WAIT  = 2'b01;
  localparam logic [1:0]       S_ERROR     = 2'b10;
  localparam logic [7:0]       L_WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_CNT_MAX   = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_inc;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_mw;
  logic             w_lu;

  always_comb begin
    w_lu = LOAD_E && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
    w_wait_inc = r_wait_cnt + 8'd1;
    case (r_state)
      S_RUN:      w_mw = MEM_REQ_M && !MEM_READY;
      S_MEM_WAIT: w_mw = !MEM_READY;
      default:    w_mw = 1'b0;
    endcase
  end

  // The timeout fires on the same edge the wait counter reaches TIMEOUT-1.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN: begin
        if (w_mw) w_next_state = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (MEM_READY)                      w_next_state = S_RUN;
        else if (w_wait_inc == L_WAIT_LAST) w_next_state = S_ERROR;
      end
      S_ERROR: w_next_state = S_ERROR;
      default: w_next_state = S_RUN;
    endcase
  end

  always_comb begin
    STALL_F = 1'b0;
    STALL_D = 1'b0;
    STALL_E = 1'b0;
    STALL_M = 1'b0;
    FLUSH_D = 1'b0;
    FLUSH_E = 1'b0;
    FLUSH_W = 1'b0;
    FWD_A_E = 2'b00;
    FWD_B_E = 2'b00;
    if (rst) begin
      if (REGWRITE_M && (RD_M != 5'd0) && (RD_M == RS1_E))      FWD_A_E = 2'b10;
      else if (REGWRITE_W && (RD_W != 5'd0) && (RD_W == RS1_E)) FWD_A_E = 2'b01;
      if (REGWRITE_M && (RD_M != 5'd0) && (RD_M == RS2_E))      FWD_B_E = 2'b10;
      else if (REGWRITE_W && (RD_W != 5'd0) && (RD_W == RS2_E)) FWD_B_E = 2'b01;

      // Memory wait and bus error freeze everything; branch outranks load-use.
      if ((r_state == S_ERROR) || w_mw) begin
        STALL_F = 1'b1;
        STALL_D = 1'b1;
        STALL_E = 1'b1;
        STALL_M = 1'b1;
        FLUSH_W = 1'b1;
      end else if (PCSRC_E) begin
        FLUSH_D = 1'b1;
        FLUSH_E = 1'b1;
      end else if (w_lu) begin
        STALL_F = 1'b1;
        STALL_D = 1'b1;
        FLUSH_E = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= 8'd0;
      r_bus_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_RUN) && w_mw)
        r_wait_cnt <= 8'd0;
      else if ((r_state == S_MEM_WAIT) && !MEM_READY)
        r_wait_cnt <= w_wait_inc;
      if (w_next_state == S_ERROR)
        r_bus_err <= 1'b1;
      if (STALL_F && (r_stall_cnt != L_CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign BUS_ERR   = r_bus_err;
  assign STALL_CNT = r_stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16; maximum memory-wait cycles before a bus error is declared (range 2..255).
REQ-002 Parameter CNT_W, default 16; width of the stall-cycle performance counter.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low. Ports are clk and rst; rst=0 is sampled on the rising clk edge.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 RS1_D, RS2_D  input  5 each  source register numbers of the instruction in Decode.
REQ-007 RS1_E, RS2_E, RD_E  input  5 each  source and destination register numbers in Execute.
REQ-008 RD_M, RD_W  input  5 each  destination register numbers in Memory and Writeback.
REQ-009 REGWRITE_M, REGWRITE_W  input  1 each  register-write enables for Memory and Writeback.
REQ-010 LOAD_E  input  1  the instruction in Execute is a load.
REQ-011 PCSRC_E  input  1  a taken branch or jump is resolved in Execute.
REQ-012 MEM_REQ_M  input  1  data-memory access in progress in Memory.
REQ-013 MEM_READY  input  1  data memory has completed the access this cycle.
REQ-014 STALL_F, STALL_D, STALL_E, STALL_M  output  1 each  hold the pipeline register EN pins; 1 = hold, 0 = load.
REQ-015 FLUSH_D, FLUSH_E, FLUSH_W  output  1 each  clear the pipeline register CLR pins; 1 = clear on the next edge.
REQ-016 FWD_A_E, FWD_B_E  output  2 each  Execute operand select: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
REQ-017 BUS_ERR  output  1  sticky memory-timeout error flag.
REQ-018 STALL_CNT  output  CNT_W  saturating count of cycles with STALL_F=1.

Function
REQ-019 Forwarding logic SHALL be combinational. FWD_A_E SHALL be 10 if REGWRITE_M & RD_M!=0 & RD_M==RS1_E. Otherwise it SHALL be 01 if REGWRITE_W & RD_W!=0 & RD_W==RS1_E. Otherwise it SHALL be 00. FWD_B_E uses the same rule with RS2_E.
REQ-020 The load-use condition lu SHALL be LOAD_E & RD_E!=0 & (RD_E==RS1_D | RD_E==RS2_D).
REQ-021 The FSM SHALL have three states: RUN, MEM_WAIT and ERROR. All outputs except STALL_CNT and BUS_ERR SHALL be combinational from the state and the inputs.
REQ-022 RUN to MEM_WAIT SHALL occur when MEM_REQ_M=1 and MEM_READY=0. In that same cycle, mw=1.
REQ-023 In MEM_WAIT, mw=1 while MEM_READY=0. When MEM_READY=1, mw=0 in that cycle and the FSM SHALL return to RUN on the next edge.
REQ-024 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle with MEM_READY=0. When the counter reaches TIMEOUT-1 with MEM_READY still 0, the FSM SHALL go to ERROR.
REQ-025 In ERROR, BUS_ERR=1 and STALL_F/D/E/M=1. FLUSH_W=1 and all other flushes are 0. The block leaves ERROR only on reset.
REQ-026 When mw=1 (in RUN or MEM_WAIT): STALL_F/D/E/M=1, FLUSH_W=1, FLUSH_D=FLUSH_E=0. lu and PCSRC_E are ignored.
REQ-027 When mw=0 and PCSRC_E=1: FLUSH_D=FLUSH_E=1 and all stalls are 0. The branch takes priority over lu.
REQ-028 When mw=0, PCSRC_E=0 and lu=1: STALL_F=STALL_D=1, FLUSH_E=1, and STALL_E=STALL_M=FLUSH_D=FLUSH_W=0.
REQ-029 Otherwise, all stalls and flushes SHALL be 0.
REQ-030 STALL_CNT SHALL increment by 1 on every edge where STALL_F=1. It SHALL hold at 2^CNT_W-1 once it saturates.

Reset
REQ-031 While rst=0 on an edge: state becomes RUN, the wait counter becomes 0, BUS_ERR becomes 0 and STALL_CNT becomes 0.
REQ-032 While rst=0: all STALL_*, FLUSH_* and FWD_* outputs SHALL be driven 0, regardless of the other inputs.
REQ-033 Reset asserted during MEM_WAIT or ERROR SHALL return the block to RUN with no residual stall after rst goes to 1.

Verification
REQ-034 Forwarding: RD_M=RD_W=5=RS1_E, REGWRITE_M=REGWRITE_W=1 -> FWD_A_E=10. Then RD_M=0 -> 01. Then RD_W=0 -> 00.
REQ-035 Load-use: LOAD_E=1, RD_E=7, RS2_D=7 -> STALL_F=STALL_D=FLUSH_E=1 for 1 cycle and STALL_CNT=1. The same stimulus with RD_E=0 -> no stall.
REQ-036 Branch during load-use: PCSRC_E=1 with the REQ-035 stimulus -> FLUSH_D=FLUSH_E=1 and STALL_F=0.
REQ-037 Memory wait: MEM_REQ_M=1, MEM_READY low for 3 cycles then high -> all four stalls and FLUSH_W are 1 for exactly 3 cycles, all 0 in the ready cycle, and STALL_CNT=3.
REQ-038 Timeout: TIMEOUT=4, MEM_READY held 0 -> BUS_ERR=1 after the 4th wait edge and stalls stay 1. Then rst=0 for 1 edge -> BUS_ERR=0 and stalls are 0.
REQ-039 Saturation: CNT_W=4, 20 stall cycles -> STALL_CNT=15.
